rr_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one counter-based resource (such as the 2-bit counter datapath) between 4 requesters.
- A 2-bit wrapping priority pointer, itself a counter, rotates fairness after every completed grant.
- Sits between requesting blocks and the shared resource.
- Grants are exclusive, one-hot, and held until the owner releases.

---
 rtl/rr_arbiter_4_if.sv | 28 ++
 rtl/rr_arbiter_4.sv | 155 +++++++++++++++
 tb/tb_rr_arbiter_4.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting blocks (master side) and the
// round-robin arbiter (slave side).
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with held, one-hot grants and a rotating pointer.
// Optional forced release after HOLD_MAX cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_4_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] grant_r;
    logic [3:0] grant_s;
    logic [1:0] gnt_id_r;
    logic [1:0] gnt_id_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;
    logic [1:0] winner_s;
    logic       busy_r;
    logic       busy_s;
    logic       timeout_r;
    logic       timeout_s;
    logic       release_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_r;
    logic [7:0] hold_s;
`endif

    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_check
        $error("rr_arbiter_4: HOLD_MAX must lie in 2..255");
    end

    // First set request bit found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Next-state, next-output and pointer logic for the IDLE/GRANT machine.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        gnt_id_s  = gnt_id_r;
        busy_s    = busy_r;
        ptr_s     = ptr_r;
        timeout_s = 1'b0;
        winner_s  = rr_pick(bus.req, ptr_r);
        release_s = bus.done | ~bus.req[gnt_id_r];
`ifdef ARB_TIMEOUT_EN
        hold_s    = hold_r;
`endif
        case (state_r)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                hold_s = 8'd0;
`endif
                if (bus.req != 4'b0000) begin
                    state_s  = GRANT;
                    grant_s  = onehot4(winner_s);
                    gnt_id_s = winner_s;
                    busy_s   = 1'b1;
                end else begin
                    grant_s  = 4'b0000;
                    busy_s   = 1'b0;
                end
            end
            GRANT: begin
                // Owner keeps gnt_id after release; the pointer moves just past it.
                if (release_s) begin
                    state_s = IDLE;
                    grant_s = 4'b0000;
                    busy_s  = 1'b0;
                    ptr_s   = gnt_id_r + 2'd1;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_r == HOLD_LAST) begin
                    state_s   = IDLE;
                    grant_s   = 4'b0000;
                    busy_s    = 1'b0;
                    ptr_s     = gnt_id_r + 2'd1;
                    timeout_s = 1'b1;
                end else begin
                    hold_s = hold_r + 8'd1;
`else
                end else begin
                    busy_s = 1'b1;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_r   <= 4'b0000;
            gnt_id_r  <= 2'b00;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            ptr_r     <= 2'b00;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            gnt_id_r  <= gnt_id_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
            ptr_r     <= ptr_s;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold-time counter for the current grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= 8'd0;
        end else begin
            hold_r <= hold_s;
        end
    end
`endif

    assign bus.grant   = grant_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: the driver queues hand-computed expected
// outputs, a monitor compares them one cycle after the sampling edge.
module tb_rr_arbiter_4;

    typedef struct packed {
        logic [15:0] step;
        logic [3:0]  grant;
        logic [1:0]  gnt_id;
        logic        busy;
        logic        timeout;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   step_no;
    exp_t exp_q[$];

    rr_arbiter_4_if ifc ();

    rr_arbiter_4 #(.HOLD_MAX(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector after an edge and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic d,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic eb, input logic et);
        exp_t e;
        @(posedge clk);
        #2;
        reset    = r;
        ifc.req  = rq;
        ifc.done = d;
        e.step    = 16'(step_no);
        e.grant   = eg;
        e.gnt_id  = eid;
        e.busy    = eb;
        e.timeout = et;
        exp_q.push_back(e);
        step_no++;
    endtask

    // Monitor: one-hot check every cycle, scoreboard compare whenever an entry is due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if ($countones(ifc.grant) > 1) begin
                errors++;
                $display("FAIL onehot grant=%b required at most one bit set", ifc.grant);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({ifc.grant, ifc.gnt_id, ifc.busy, ifc.timeout} !==
                    {e.grant, e.gnt_id, e.busy, e.timeout}) begin
                    errors++;
                    $display("FAIL step%0d got grant=%b gnt_id=%0d busy=%b timeout=%b required grant=%b gnt_id=%0d busy=%b timeout=%b",
                             e.step, ifc.grant, ifc.gnt_id, ifc.busy, ifc.timeout,
                             e.grant, e.gnt_id, e.busy, e.timeout);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [4];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        checks   = 0;
        errors   = 0;
        step_no  = 0;
        reset    = 1'b1;
        ifc.req  = 4'b0000;
        ifc.done = 1'b0;

        // Reset with all requests pending.
        step(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Single request, release, then ptr=3 picks requester 3.
        step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        // Fairness with all requests held: 0,1,2,3 then wrap to 0.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b1111, 1'b0, seq[k], 2'(k), 1'b1, 1'b0);
            step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'(k), 1'b0, 1'b0);
        end
        step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Request drop by owner 1, then ptr=2 scans 2,3,0.
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        // done and req drop together advance ptr only once (to 1).
        step(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 4'b0110, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        // done ignored while idle; ptr stays at 2.
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        // Reset mid-grant returns ptr to 0.
        step(1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Long hold by requester 1.
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1);
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        // Normal release on the last hold cycle wins over the timeout.
        step(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
`else
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
`endif
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
